// File: rtl/sram_arbiter.sv
// Two-port arbiter sharing the sram_ctrl command interface between the CPU (port 0) and DMA (port 1).
// Optional build macro SRAM_ARB_RR_EN: round-robin IDLE tie-break instead of fixed port-0 priority.
//
// state | meaning
// IDLE  | no owner, s_strobe low, both ports stalled
// OWN0  | port 0 drives sram_ctrl, port 1 stalled
// OWN1  | port 1 drives sram_ctrl, port 0 stalled
module sram_arbiter #(
   parameter int ADDR_W    = 17,
   parameter int BURST_MAX = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [31:0]       m0_wrdata,
   input  logic [3:0]        m0_bytesel,
   input  logic              m0_wren,
   input  logic              m0_strobe,
   output logic              m0_wait,
   output logic [31:0]       m0_rddata,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [31:0]       m1_wrdata,
   input  logic [3:0]        m1_bytesel,
   input  logic              m1_wren,
   input  logic              m1_strobe,
   output logic              m1_wait,
   output logic [31:0]       m1_rddata,
   output logic [ADDR_W-1:0] s_addr,
   output logic [31:0]       s_wrdata,
   output logic [3:0]        s_bytesel,
   output logic              s_wren,
   output logic              s_strobe,
   input  logic              s_wait,
   input  logic [31:0]       s_rddata,
   output logic [1:0]        grant
);
   localparam int             CNT_W     = $clog2(BURST_MAX + 1);
   localparam logic [CNT_W:0] BURST_LIM = (CNT_W + 1)'(BURST_MAX);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_OWN0 = 2'b01,
      ST_OWN1 = 2'b10
   } state_t;

   state_t           state, state_nxt, oth_state;
   logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
   logic [CNT_W:0]   cnt_inc;
   logic             own_strobe, oth_strobe;
   logic             tie_to_1;

`ifdef SRAM_ARB_RR_EN
   logic last, last_nxt;
   assign tie_to_1 = ~last;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) last <= 1'b1;
      else          last <= last_nxt;
   end
`else
   assign tie_to_1 = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         burst_cnt <= '0;
         grant     <= 2'b00;
      end else begin
         state     <= state_nxt;
         burst_cnt <= burst_cnt_nxt;
         grant     <= {state_nxt == ST_OWN1, state_nxt == ST_OWN0};
      end
   end

   always_comb begin
      state_nxt     = state;
      burst_cnt_nxt = burst_cnt;
`ifdef SRAM_ARB_RR_EN
      last_nxt      = last;
`endif
      cnt_inc    = {1'b0, burst_cnt} + (CNT_W + 1)'(1);
      own_strobe = (state == ST_OWN1) ? m1_strobe : m0_strobe;
      oth_strobe = (state == ST_OWN1) ? m0_strobe : m1_strobe;
      oth_state  = (state == ST_OWN1) ? ST_OWN0 : ST_OWN1;
      case (state)
         ST_IDLE: begin
            if (m0_strobe && m1_strobe) state_nxt = tie_to_1 ? ST_OWN1 : ST_OWN0;
            else if (m0_strobe)         state_nxt = ST_OWN0;
            else if (m1_strobe)         state_nxt = ST_OWN1;
         end
         ST_OWN0, ST_OWN1: begin
            // A dropped strobe releases ownership even mid-transaction.
            if (!own_strobe) begin
               state_nxt     = oth_strobe ? oth_state : ST_IDLE;
               burst_cnt_nxt = '0;
`ifdef SRAM_ARB_RR_EN
               last_nxt      = (state == ST_OWN1);
`endif
            end else if (!s_wait) begin
               if (oth_strobe && cnt_inc >= BURST_LIM) begin
                  state_nxt     = oth_state;
                  burst_cnt_nxt = '0;
`ifdef SRAM_ARB_RR_EN
                  last_nxt      = (state == ST_OWN1);
`endif
               end else if (cnt_inc >= BURST_LIM) begin
                  burst_cnt_nxt = BURST_LIM[CNT_W-1:0];
               end else begin
                  burst_cnt_nxt = cnt_inc[CNT_W-1:0];
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      s_addr    = '0;
      s_wrdata  = '0;
      s_bytesel = '0;
      s_wren    = 1'b0;
      s_strobe  = 1'b0;
      m0_wait   = 1'b1;
      m1_wait   = 1'b1;
      m0_rddata = '0;
      m1_rddata = '0;
      case (state)
         ST_OWN0: begin
            s_addr    = m0_addr;
            s_wrdata  = m0_wrdata;
            s_bytesel = m0_bytesel;
            s_wren    = m0_wren;
            s_strobe  = m0_strobe;
            m0_wait   = s_wait;
            m0_rddata = s_rddata;
         end
         ST_OWN1: begin
            s_addr    = m1_addr;
            s_wrdata  = m1_wrdata;
            s_bytesel = m1_bytesel;
            s_wren    = m1_wren;
            s_strobe  = m1_strobe;
            m1_wait   = s_wait;
            m1_rddata = s_rddata;
         end
         default: ;
      endcase
   end
endmodule
